// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding and ALU op codes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant: round-robin on last_grant, or fixed priority to requester 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module arb_rr2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = {valid[1] & ~valid[0], valid[0]};
`else
  // On contention the side that did not win last time goes first.
  assign grant[0] = valid[0] & (~valid[1] |  last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one op in flight.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) over round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  output logic [CTRL_WIDTH-1:0] alu_control,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_over_flow,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_over_flow,
  output logic                  rsp_zero
);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  id;
  } op_t;

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       last_grant;
  logic       accept;
  op_t        op_q, op_sel;

  arb_rr2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) & grant[0];
    req1_ready = (state == IDLE) & grant[1];
    rsp_valid  = (state == RESP);
  end

  // Grants already imply valid, so any ready is an acceptance.
  assign accept = req0_ready | req1_ready;
  assign op_sel = req1_ready ? op_t'{req1_ctrl, req1_a, req1_b, 1'b1}
                             : op_t'{req0_ctrl, req0_a, req0_b, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      last_grant    <= 1'b1;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_carry     <= 1'b0;
      rsp_over_flow <= 1'b0;
      rsp_zero      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_sel;
        last_grant <= op_sel.id;
      end
      if (state == EXEC) begin
        rsp_id        <= op_q.id;
        rsp_result    <= alu_result;
        rsp_carry     <= alu_carry;
        rsp_over_flow <= alu_over_flow;
        rsp_zero      <= alu_zero;
      end
    end
  end

  // ALU operands come straight from the op register, so they hold between ops.
  assign alu_control = op_q.ctrl;
  assign alu_a       = op_q.a;
  assign alu_b       = op_q.b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [CW-1:0] req0_ctrl, req1_ctrl, alu_control;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic          alu_carry, alu_over_flow, alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_over_flow, rsp_zero;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         c, o, z;
  } rsp_t;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_over_flow(alu_over_flow),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_over_flow(rsp_over_flow),
    .rsp_zero(rsp_zero)
  );

  function automatic rsp_t ref_alu(input logic id, input logic [2:0] c,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    logic [W:0] s;
    r = '0;
    r.id = id;
    case (c)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0]; r.c = s[W];
        r.o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r.res = s[W-1:0]; r.c = s[W];
        r.o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      ALU_AND: r.res = a & b;
      ALU_OR:  r.res = a | b;
      ALU_XOR: r.res = a ^ b;
      ALU_SLT: r.res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL: r.res = a << b[4:0];
      default: r.res = a >> b[4:0];
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  rsp_t alu_t;
  assign alu_t         = ref_alu(1'b0, alu_control, alu_a, alu_b);
  assign alu_result    = alu_t.res;
  assign alu_carry     = alu_t.c;
  assign alu_over_flow = alu_t.o;
  assign alu_zero      = alu_t.z;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  rsp_t          q[$];
  logic          exp_last = 1'b1;
  logic [CW-1:0] exp_ctrl = '0;
  logic [W-1:0]  exp_a = '0, exp_b = '0;
  logic          rst_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic last);
    if (!(v0 && v1)) return {v1, v0};
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return last ? 2'b01 : 2'b10;
`endif
  endfunction

  task automatic monitor();
    logic [1:0] eg;
    rsp_t e;
    eg = (q.size() == 0) ? exp_grant(req0_valid, req1_valid, exp_last) : 2'b00;
    chk("ready", 64'({req1_ready, req0_ready}), 64'(eg));
    chk("alu_control_hold", 64'(alu_control), 64'(exp_ctrl));
    chk("alu_a_hold", 64'(alu_a), 64'(exp_a));
    chk("alu_b_hold", 64'(alu_b), 64'(exp_b));
    chk("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0 && cyc >= acc_cyc + 2));
    if (rsp_valid && q.size() != 0) begin
      e = q[0];
      chk("rsp_id", 64'(rsp_id), 64'(e.id));
      chk("rsp_result", 64'(rsp_result), 64'(e.res));
      chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
      chk("rsp_over_flow", 64'(rsp_over_flow), 64'(e.o));
      chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
      if (rsp_ready) void'(q.pop_front());
    end
    if (eg != 2'b00) begin
      if (eg[1]) begin
        q.push_back(ref_alu(1'b1, req1_ctrl, req1_a, req1_b));
        exp_ctrl = req1_ctrl; exp_a = req1_a; exp_b = req1_b;
      end else begin
        q.push_back(ref_alu(1'b0, req0_ctrl, req0_a, req0_b));
        exp_ctrl = req0_ctrl; exp_a = req0_a; exp_b = req0_b;
      end
      exp_last = eg[1];
      acc_cyc  = cyc;
    end
  endtask

  task automatic reset_values();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_rsp_flags", 64'({rsp_carry, rsp_over_flow, rsp_zero}), 64'(0));
    chk("rst_alu", 64'({alu_control, alu_a, alu_b} != '0), 64'(0));
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) monitor();
    if (rst_chk && !rst) begin reset_values(); rst_chk = 1'b0; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    q.delete();
    exp_last = 1'b1;
    exp_ctrl = '0; exp_a = '0; exp_b = '0;
    rst_chk  = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin cycle(); n++; end
    chk("timeout", 64'(q.size() != 0), 64'(0));
  endtask

  task automatic op(input logic id, input logic [2:0] c, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    if (id) begin req1_ctrl = c; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_ctrl = c; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ctrl = '0; req0_a = '0; req0_b = '0;
    req1_ctrl = '0; req1_a = '0; req1_b = '0;
    repeat (2) cycle();
    rst = 1'b0; clear_model();
    repeat (2) cycle();

    // Contention: winners must alternate starting with requester 0.
    req0_ctrl = ALU_SUB; req0_a = 32'd10;   req0_b = 32'd10;   req0_valid = 1'b1;
    req1_ctrl = ALU_OR;  req1_a = 32'hF0;   req1_b = 32'h0F;   req1_valid = 1'b1;
    repeat (12) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(20);

    op(1'b0, ALU_ADD, 32'd5, 32'd7);
    op(1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    op(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    op(1'b1, ALU_SUB, 32'd3, 32'd5);
    op(1'b0, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    op(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    op(1'b0, ALU_SLL, 32'd1, 32'd31);
    op(1'b1, ALU_SRL, 32'h8000_0000, 32'd4);
    op(1'b0, ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // rsp_ready with nothing pending must not produce a response.
    rsp_ready = 1'b1;
    repeat (3) cycle();

    // Backpressure with requester 0 waiting the whole time.
    rsp_ready = 1'b0;
    req1_ctrl = ALU_XOR; req1_a = 32'h1234_5678; req1_b = 32'hFFFF_0000; req1_valid = 1'b1;
    cycle();
    req1_valid = 1'b0;
    req0_ctrl = ALU_ADD; req0_a = 32'd100; req0_b = 32'd23; req0_valid = 1'b1;
    repeat (2) cycle();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    repeat (5) cycle();
    rsp_ready = 1'b1;
    cycle();
    cycle();
    req0_valid = 1'b0;
    wait_idle(20);

    // A short request while busy must never be granted.
    req0_ctrl = ALU_OR; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    req1_ctrl = ALU_ADD; req1_a = 32'd9; req1_b = 32'd9; req1_valid = 1'b1;
    cycle();
    req1_valid = 1'b0;
    wait_idle(20);
    repeat (3) cycle();

    // Reset while requester 0's op is in EXEC.
    req0_ctrl = ALU_ADD; req0_a = 32'd40; req0_b = 32'd2; req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0; clear_model();
    cycle();
    req0_ctrl = ALU_SUB; req0_a = 32'd8; req0_b = 32'd3; req0_valid = 1'b1;
    req1_ctrl = ALU_AND; req1_a = 32'hF;  req1_b = 32'h3; req1_valid = 1'b1;
    cycle();
    chk("post_rst_owner", 64'(exp_last), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(20);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/result width; CTRL_WIDTH, 3, ALU control width.
REQ-002 Clock and reset SHALL be one clock, reset synchronous and active-high: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-003 req0_valid/req1_valid input 1: requester 0/1 presents an operation.
REQ-004 req0_ready/req1_ready output 1: requester 0/1 operation accepted this cycle.
REQ-005 req0_ctrl/req1_ctrl input CTRL_WIDTH; req0_a, req0_b, req1_a, req1_b input WIDTH: ALU control code and operands.
REQ-006 alu_control output CTRL_WIDTH; alu_a, alu_b output WIDTH: drive the shared ALU.
REQ-007 alu_result input WIDTH; alu_carry, alu_over_flow, alu_zero input 1: shared ALU outputs (combinational).
REQ-008 rsp_valid output 1; rsp_ready input 1: response handshake.
REQ-009 rsp_id output 1 (0/1 = owning requester); rsp_result output WIDTH; rsp_carry, rsp_over_flow, rsp_zero output 1.

Function
REQ-010 FSM SHALL have states IDLE, EXEC, RESP; at most one operation outstanding.
REQ-011 req0_ready/req1_ready SHALL be asserted only in IDLE, one-hot or zero, and only for the winning valid requester (combinational from valids).
REQ-012 Acceptance (valid && ready) in cycle N SHALL register ctrl, a, b and owner id, and move IDLE->EXEC.
REQ-013 In EXEC (cycle N+1) alu_control/alu_a/alu_b SHALL come from the registered values; at the end of N+1 alu_result and flags SHALL be captured into rsp_* registers; EXEC->RESP.
REQ-014 rsp_valid SHALL be 1 exactly in RESP (from cycle N+2); rsp_* SHALL hold stable until rsp_valid && rsp_ready, then RESP->IDLE; a new acceptance is possible no earlier than the following cycle (min 3 cycles per operation).
REQ-015 Outside EXEC, alu_control/alu_a/alu_b SHALL hold their last registered values (no toggling).
REQ-016 Round-robin: a last-grant bit SHALL record the most recent winner; when both valid in IDLE, the requester not equal to last-grant wins; with one valid, it wins regardless.
REQ-017 A requester dropping valid before acceptance SHALL NOT be granted; request inputs SHALL be ignored outside IDLE.
REQ-018 rsp_ready asserted without rsp_valid SHALL have no effect.

Reset
REQ-019 rst asserted at any clock edge, including mid-EXEC or RESP, SHALL force IDLE and abort the operation with no response.
REQ-020 After reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp flags=0, alu_control=0, alu_a=0, alu_b=0, last-grant=1 (requester 0 wins first contention); req*_ready follow REQ-011 from the first post-reset cycle.

Configuration
REQ-021 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and last-grant is unused; when undefined, REQ-016 round-robin applies.

Structure
REQ-022 Shared package alu_arb_pkg SHALL hold the FSM state encoding and the ALU control code constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLL=110, SRL=111).
REQ-023 Grant logic SHALL be a sub-module arb_rr2 (two valids + last-grant in, one-hot grant out, honouring ALU_ARB_FIXED_PRIO_EN); the ALU itself is instantiated outside the block.

Verification
REQ-024 Single op: req0 ADD a=5 b=7, rsp_ready=1 -> rsp_valid at N+2, rsp_result=12, rsp_id=0, carry=0, zero=0.
REQ-025 Contention: both valid continuously, req0 SUB 10-10, req1 OR 0xF0|0x0F -> grants alternate 0,1,0,...; first rsp zero=1, result 0; second result 0xFF, id=1 (fixed-priority build: always id=0).
REQ-026 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req*_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-027 Overflow/carry: ADD 0x7FFFFFFF+1 -> over_flow=1, result 0x80000000; ADD 0xFFFFFFFF+1 -> carry=1, zero=1.
REQ-028 Reset mid-EXEC: rst during EXEC -> next cycle rsp_valid=0, all outputs at REQ-020 values, next request granted to requester 0.
